// File: rtl/controle_ula.sv
// controle_ula: multi-cycle control unit for an 8-bit accumulator CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB/HALT and drives datapath strobes.
`default_nettype none

module controle_ula (
  input  logic       c,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [2:0] ula_op,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       halt,
  output logic [2:0] state,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;
  localparam logic [2:0] OP_HLT  = 3'b111;

  state_t     cur_state;
  state_t     next_state;
  logic [7:0] ir;
  logic [7:0] retired_cnt;
  logic       retire;
  logic [2:0] opcode;

  assign opcode = ir[7:5];

  // Operand bits travel with the datapath's own copy of the instruction.
  logic unused_operand;
  assign unused_operand = ^ir[4:0];

  always_ff @(posedge c) begin
    if (reset) begin
      cur_state   <= FETCH;
      ir          <= 8'h00;
      retired_cnt <= 8'h00;
    end else begin
      cur_state <= next_state;
      if (ir_load) begin
        ir <= instr;
      end
      if (retire) begin
        retired_cnt <= retired_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    next_state = cur_state;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    ula_op     = 3'b000;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    halt       = 1'b0;

    case (cur_state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          next_state = DECODE;
        end
      end

      DECODE: begin
        if (opcode == OP_HLT) begin
          next_state = HALT;
          retire     = 1'b1;
        end else begin
          next_state = EXEC;
        end
      end

      EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_OR, OP_AND: begin
            ula_op     = opcode;
            next_state = WB;
          end
          OP_LD, OP_ST: begin
            next_state = MEM;
          end
          OP_BEQZ: begin
            ula_op     = 3'b001;
            pc_load    = zero;
            next_state = FETCH;
            retire     = 1'b1;
          end
          default: begin
            next_state = FETCH;
          end
        endcase
      end

      MEM: begin
        if (opcode == OP_LD) begin
          mem_read = 1'b1;
          if (mem_ready) begin
            next_state = WB;
          end
        end else if (opcode == OP_ST) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            next_state = FETCH;
            retire     = 1'b1;
          end
        end else begin
          next_state = FETCH;
        end
      end

      WB: begin
        reg_write  = 1'b1;
        wb_sel     = (opcode == OP_LD);
        next_state = FETCH;
        retire     = 1'b1;
      end

      HALT: begin
        halt = 1'b1;
      end

      default: begin
        next_state = FETCH;
      end
    endcase

    // While reset is held the unit presents the idle fetch request only.
    if (reset) begin
      mem_read  = 1'b1;
      mem_write = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      ula_op    = 3'b000;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
      halt      = 1'b0;
    end
  end

  assign state   = cur_state;
  assign retired = retired_cnt;

endmodule

`default_nettype wire
